wb_port_arbiter: RTL and testbench

Shares the single register-file write port between several writeback sources: ALU result, load unit and multi-cycle MUL/DIV. Each cycle it grants at most one valid requester using round-robin priority. It drives the registered write (`rf_we`, `rf_waddr`, `rf_wdata`) into the register file one cycle after the grant, so the register file's per-register write enables are sequenced from one place.

---
 rtl/wb_arb_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 52 +++++
 rtl/wb_port_arbiter.sv | 106 ++++++++++
 tb/tb_wb_port_arbiter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared constants and types for the writeback port arbiter.
// Default widths and the hard-wired zero register index.
package wb_arb_pkg;

   localparam int unsigned ZERO_REG       = 0;
   localparam int          DEF_NUM_REQ    = 3;
   localparam int          DEF_DATA_WIDTH = 32;
   localparam int          DEF_ADDR_WIDTH = 5;

   typedef struct packed {
      logic                      valid;
      logic [DEF_ADDR_WIDTH-1:0] addr;
      logic [DEF_DATA_WIDTH-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered priority pointer.
// Searches from ptr upward, wrapping; pointer moves past the winner.
module rr_arbiter
   import wb_arb_pkg::*;
#(
   parameter int N = DEF_NUM_REQ,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic [N-1:0]  req_i,
   input  logic          en_i,
   output logic [N-1:0]  gnt_o,
   output logic [PW-1:0] ptr_o
);

   localparam int SW = PW + 1;

   logic [PW-1:0] ptr_q;
   logic [PW-1:0] ptr_d;
   logic [SW-1:0] sum;
   logic [PW-1:0] idx;
   logic          found;

   // First valid request at or after ptr wins; ptr advances past it.
   always_comb begin
      gnt_o = '0;
      ptr_d = ptr_q;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr_q} + SW'(k);
         if (sum >= SW'(N)) sum = sum - SW'(N);
         idx = sum[PW-1:0];
         if (en_i && !found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            ptr_d      = (idx == PW'(N - 1)) ? '0 : idx + 1'b1;
         end
      end
   end

   // Pointer register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

   assign ptr_o = ptr_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write port arbiter: round-robin grant, registered write.
// Optional contention counter enabled by WB_ARB_STATS_EN.
module wb_port_arbiter
   import wb_arb_pkg::*;
#(
   parameter int NUM_REQ    = DEF_NUM_REQ,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          hold_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   output logic                          rf_we_o,
   output logic [ADDR_WIDTH-1:0]         rf_waddr_o,
   output logic [DATA_WIDTH-1:0]         rf_wdata_o
`ifdef WB_ARB_STATS_EN
  ,output logic [31:0]                   stall_cnt_o
`endif
);

   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]    gnt;
   logic [PW-1:0]         ptr_unused;
   logic                  grant;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_data;

   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

   rr_arbiter #(.N(NUM_REQ)) u_rr (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .req_i (req_valid_i),
      .en_i  (!hold_i && !rst_i),
      .gnt_o (gnt),
      .ptr_o (ptr_unused)
   );

   assign req_ready_o = gnt;
   assign grant       = |gnt;

   // One-hot AND-OR mux of the granted requester's address and data.
   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_addr = sel_addr
                  | ({ADDR_WIDTH{gnt[i]}} & req_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH]);
         sel_data = sel_data
                  | ({DATA_WIDTH{gnt[i]}} & req_data_i[i*DATA_WIDTH +: DATA_WIDTH]);
      end
   end

   // Capture on grant; x0 is consumed without a write pulse.
   always_comb begin
      we_d    = grant && (sel_addr != ADDR_WIDTH'(ZERO_REG));
      waddr_d = grant ? sel_addr : waddr_q;
      wdata_d = grant ? sel_data : wdata_q;
   end

   // Output register; reset discards any captured write.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign rf_we_o    = we_q;
   assign rf_waddr_o = waddr_q;
   assign rf_wdata_o = wdata_q;

`ifdef WB_ARB_STATS_EN
   logic        stall;
   logic [31:0] cnt_q, cnt_d;

   // Count cycles where a valid requester waits; saturate at all-ones.
   always_comb begin
      stall = |(req_valid_i & ~gnt);
      cnt_d = (stall && (cnt_q != '1)) ? cnt_q + 32'd1 : cnt_q;
   end

   // Contention counter register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign stall_cnt_o = cnt_q;
`else
   // Contention statistics not built in this configuration.
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (3 requesters, 5-bit addr, 32-bit data).
// Contention counter checks active when WB_ARB_STATS_EN is defined.
module tb_wb_port_arbiter;

   logic        clk;
   logic        rst;
   logic        hold;
   logic [2:0]  req_valid;
   logic [14:0] req_addr;
   logic [95:0] req_data;
   logic [2:0]  req_ready;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
`ifdef WB_ARB_STATS_EN
   logic [31:0] stall_cnt;
`endif

   int passed = 0;
   int total  = 0;

   wb_port_arbiter #(
      .NUM_REQ(3), .DATA_WIDTH(32), .ADDR_WIDTH(5)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .hold_i      (hold),
      .req_valid_i (req_valid),
      .req_addr_i  (req_addr),
      .req_data_i  (req_data),
      .req_ready_o (req_ready),
      .rf_we_o     (rf_we),
      .rf_waddr_o  (rf_waddr),
      .rf_wdata_o  (rf_wdata)
`ifdef WB_ARB_STATS_EN
     ,.stall_cnt_o (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic set_req(input int i,
                          input logic [4:0] a,
                          input logic [31:0] d);
      req_addr[i*5 +: 5]   = a;
      req_data[i*32 +: 32] = d;
   endtask

   initial begin
      rst       = 1'b1;
      hold      = 1'b0;
      req_valid = 3'b111;
      req_addr  = '0;
      req_data  = '0;
      set_req(0, 5'd10, 32'hA0A0_0000);
      set_req(1, 5'd11, 32'hA1A1_1111);
      set_req(2, 5'd12, 32'hA2A2_2222);

      // Reset with all requests valid
      #2;
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_we",    32'(rf_we),     32'h0);
      chk("rst_waddr", 32'(rf_waddr),  32'h0);
      chk("rst_wdata", rf_wdata,       32'h0);
      @(posedge clk); #1;
      chk("rst_ready_edge", 32'(req_ready), 32'h0);
      chk("rst_we_edge",    32'(rf_we),     32'h0);

      // Release reset: round-robin over six cycles
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         #1;
         chk($sformatf("rr_ready%0d", k), 32'(req_ready), 32'(1 << (k % 3)));
         @(posedge clk); #1;
         chk($sformatf("rr_we%0d", k),    32'(rf_we),    32'h1);
         chk($sformatf("rr_waddr%0d", k), 32'(rf_waddr), 32'(10 + (k % 3)));
         @(negedge clk);
      end
`ifdef WB_ARB_STATS_EN
      chk("rr_stall", stall_cnt, 32'd6);
`endif

      // Single write from req1
      req_valid = 3'b010;
      set_req(1, 5'd7, 32'hDEAD_BEEF);
      #1;
      chk("single_ready", 32'(req_ready), 32'b010);
      @(posedge clk); #1;
      chk("single_we",    32'(rf_we),    32'h1);
      chk("single_waddr", 32'(rf_waddr), 32'd7);
      chk("single_wdata", rf_wdata,      32'hDEAD_BEEF);
      @(negedge clk);
      req_valid = 3'b000;
      #1;
      chk("idle_ready", 32'(req_ready), 32'h0);
      @(posedge clk); #1;
      chk("idle_we",    32'(rf_we),    32'h0);
      chk("idle_waddr", 32'(rf_waddr), 32'd7);
      chk("idle_wdata", rf_wdata,      32'hDEAD_BEEF);

      // x0 write from req0 (ptr currently 2)
      @(negedge clk);
      req_valid = 3'b001;
      set_req(0, 5'd0, 32'd5);
      #1;
      chk("x0_ready", 32'(req_ready), 32'b001);
      @(posedge clk); #1;
      chk("x0_we",    32'(rf_we),    32'h0);
      chk("x0_waddr", 32'(rf_waddr), 32'd0);
      chk("x0_wdata", rf_wdata,      32'd5);
      @(negedge clk);
      req_valid = 3'b111;
      set_req(0, 5'd10, 32'hA0A0_0000);
      set_req(1, 5'd11, 32'hA1A1_1111);
      #1;
      chk("x0_next_ready", 32'(req_ready), 32'b010);
      @(posedge clk); #1;
      chk("x0_next_we",    32'(rf_we),    32'h1);
      chk("x0_next_waddr", 32'(rf_waddr), 32'd11);

      // Reset mid-flight while req0 (addr 3) is granted
      @(negedge clk);
      req_valid = 3'b001;
      set_req(0, 5'd3, 32'h3333_3333);
      #1;
      chk("mid_ready", 32'(req_ready), 32'b001);
      #1;
      rst       = 1'b1;
      req_valid = 3'b000;
      #1;
      chk("mid_we_async",    32'(rf_we),     32'h0);
      chk("mid_waddr_async", 32'(rf_waddr),  32'h0);
      chk("mid_ready_rst",   32'(req_ready), 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("mid_we_edge",    32'(rf_we),    32'h0);
      chk("mid_waddr_edge", 32'(rf_waddr), 32'h0);

      // Hold for three cycles with req2 valid
      @(negedge clk);
      hold      = 1'b1;
      req_valid = 3'b100;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("hold_ready%0d", k), 32'(req_ready), 32'h0);
         @(posedge clk); #1;
         chk($sformatf("hold_we%0d", k), 32'(rf_we), 32'h0);
         @(negedge clk);
      end
      hold = 1'b0;
      #1;
      chk("hold_rel_ready", 32'(req_ready), 32'b100);
`ifdef WB_ARB_STATS_EN
      chk("hold_stall", stall_cnt, 32'd3);
`endif
      @(posedge clk); #1;
      chk("hold_rel_we",    32'(rf_we),    32'h1);
      chk("hold_rel_waddr", 32'(rf_waddr), 32'd12);
      chk("hold_rel_wdata", rf_wdata,      32'hA2A2_2222);
`ifdef WB_ARB_STATS_EN
      chk("hold_stall_after", stall_cnt, 32'd3);
`endif
      @(negedge clk);
      req_valid = 3'b000;
      @(posedge clk); #1;
      chk("final_we", 32'(rf_we), 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
